// File: rtl/eth_ring_pkg.sv
// Shared types and constants for the Ethernet receive ring.
// Register map, FSM encoding, filter OUI and length-entry layout.
package eth_ring_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2,
    S_DROP = 2'd3
  } rx_state_e;

  localparam logic [4:0] REG_MAC_LO = 5'd0;
  localparam logic [4:0] REG_MAC_HI = 5'd1;
  localparam logic [4:0] REG_STATUS = 5'd2;
  localparam logic [4:0] REG_TAIL   = 5'd3;
  localparam logic [4:0] REG_DROPS  = 5'd4;
  localparam logic [4:0] REG_RUNT   = 5'd5;

  localparam int TRUNC_BIT = 15;
  localparam logic [23:0] MCAST_OUI = 24'h01005E;
  localparam logic [15:0] HDR_LAST = 16'd5;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_mac_filter.sv
// Destination MAC acceptance: multicast OUI, broadcast,
// station address match, or promiscuous mode.
module eth_mac_filter
  import eth_ring_pkg::*;
(
  input  logic [47:0] dmac_i,
  input  logic [47:0] mac_addr_i,
  input  logic        promisc_i,
  output logic        accept_o
);

  assign accept_o = promisc_i
                  | (dmac_i[47:24] == MCAST_OUI)
                  | (&dmac_i)
                  | (dmac_i == mac_addr_i);

endmodule

// File: rtl/eth_rx_ring.sv
// Receive ring manager: filters GMII frames into an NBUF-slot
// buffer RAM and exposes pointers, counters and IRQ to the CPU.
module eth_rx_ring
  import eth_ring_pkg::*;
#(
  parameter int unsigned NBUF      = 8,
  parameter int unsigned BUF_BYTES = 2048,
  parameter logic [47:0] MAC_RESET = 48'h230100890702,
  localparam int unsigned BW = $clog2(NBUF),
  localparam int unsigned AW = $clog2(BUF_BYTES),
  localparam int unsigned PW = BW + 1
) (
  input  logic             msoc_clk,
  input  logic             rstn,
  input  logic [7:0]       rx_tdata,
  input  logic             rx_tvalid,
  input  logic             rx_tlast,
  input  logic             rx_tuser,
  output logic             buf_we,
  output logic [BW+AW-1:0] buf_addr,
  output logic [7:0]       buf_wdata,
  input  logic             reg_sel,
  input  logic             reg_we,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             eth_irq
);

  localparam logic [15:0] MAXB = 16'(BUF_BYTES);

  rx_state_e state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic trunc_q, trunc_d;
  logic [47:0] dmac_q, dmac_d;
  logic [47:0] mac_q, mac_d;
  logic irq_en_q, irq_en_d;
  logic promisc_q, promisc_d;
  logic ptr_err_q, ptr_err_d;
  logic [15:0] ovf_q, ovf_d;
  logic [15:0] bad_q, bad_d;
  logic [15:0] runt_q, runt_d;
  logic [15:0] len_q [NBUF];
  logic we_q, we_d;
  logic [BW+AW-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic irq_q, irq_d;

  logic [PW-1:0] count, count_d, tail_step;
  logic full, accept, commit;
  logic [15:0] len_ent;
  logic [BW-1:0] slot;
  logic unused_bits;

  assign count = head_q - tail_q;
  assign full = (count == PW'(NBUF));
  assign slot = head_q[BW-1:0];
  assign tail_step = reg_wdata[PW-1:0] - tail_q;
  assign unused_bits = ^{reg_wdata, bcnt_d[15]};

  eth_mac_filter u_filter (
    .dmac_i     (dmac_d),
    .mac_addr_i (mac_q),
    .promisc_i  (promisc_q),
    .accept_o   (accept)
  );

  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    bcnt_d = bcnt_q;
    trunc_d = trunc_q;
    dmac_d = dmac_q;
    mac_d = mac_q;
    irq_en_d = irq_en_q;
    promisc_d = promisc_q;
    ptr_err_d = ptr_err_q;
    ovf_d = ovf_q;
    bad_d = bad_q;
    runt_d = runt_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    commit = 1'b0;
    len_ent = '0;

    if (rx_tvalid) begin
      unique case (state_q)
        S_IDLE: begin
          trunc_d = 1'b0;
          dmac_d = {40'h0, rx_tdata};
          if (full) begin
            ovf_d = sat_inc(ovf_q);
            state_d = rx_tlast ? S_IDLE : S_DROP;
          end else begin
            we_d = 1'b1;
            addr_d = {slot, {AW{1'b0}}};
            wdata_d = rx_tdata;
            bcnt_d = 16'd1;
            if (rx_tlast) runt_d = sat_inc(runt_q);
            else state_d = S_HDR;
          end
        end
        S_HDR: begin
          we_d = 1'b1;
          addr_d = {slot, bcnt_q[AW-1:0]};
          wdata_d = rx_tdata;
          bcnt_d = bcnt_q + 16'd1;
          dmac_d = {dmac_q[39:0], rx_tdata};
          if (rx_tlast) begin
            runt_d = sat_inc(runt_q);
            state_d = S_IDLE;
          end else if (bcnt_q == HDR_LAST) begin
            state_d = accept ? S_BODY : S_DROP;
          end
        end
        S_BODY: begin
          if (bcnt_q < MAXB) begin
            we_d = 1'b1;
            addr_d = {slot, bcnt_q[AW-1:0]};
            wdata_d = rx_tdata;
            bcnt_d = bcnt_q + 16'd1;
          end else begin
            trunc_d = 1'b1;
          end
          if (rx_tlast) begin
            state_d = S_IDLE;
            if (rx_tuser) begin
              bad_d = sat_inc(bad_q);
            end else begin
              commit = 1'b1;
              head_d = head_q + 1'b1;
            end
          end
        end
        S_DROP: if (rx_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    len_ent[TRUNC_BIT] = trunc_d;
    len_ent[TRUNC_BIT-1:0] = bcnt_d[14:0];

    // Tail legality uses the pre-commit count even if head moves now
    if (reg_sel && reg_we) begin
      case (reg_addr)
        REG_MAC_LO: mac_d[31:0] = reg_wdata;
        REG_MAC_HI: begin
          irq_en_d = reg_wdata[31];
          promisc_d = reg_wdata[30];
          mac_d[47:32] = reg_wdata[15:0];
        end
        REG_TAIL: begin
          if (tail_step <= count) tail_d = reg_wdata[PW-1:0];
          else ptr_err_d = 1'b1;
        end
        REG_RUNT: if (reg_wdata[31]) ptr_err_d = 1'b0;
        default: ;
      endcase
    end

    count_d = head_d - tail_d;
    irq_d = irq_en_d & (count_d != '0);

    rdata_d = rdata_q;
    if (reg_sel && !reg_we) begin
      rdata_d = '0;
      unique case (1'b1)
        reg_addr == REG_MAC_LO: rdata_d = mac_q[31:0];
        reg_addr == REG_MAC_HI:
          rdata_d = {irq_en_q, promisc_q, 14'h0, mac_q[47:32]};
        reg_addr == REG_STATUS: begin
          rdata_d[31] = irq_q;
          rdata_d[30] = full;
          rdata_d[16 +: PW] = count;
          rdata_d[8 +: PW] = head_q;
          rdata_d[0 +: PW] = tail_q;
        end
        reg_addr == REG_TAIL: rdata_d[0 +: PW] = tail_q;
        reg_addr == REG_DROPS: rdata_d = {bad_q, ovf_q};
        reg_addr == REG_RUNT: rdata_d = {ptr_err_q, 15'h0, runt_q};
        reg_addr[4] && ({1'b0, reg_addr[3:0]} < 5'(NBUF)):
          rdata_d = {16'h0, len_q[reg_addr[BW-1:0]]};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      head_q <= '0;
      tail_q <= '0;
      bcnt_q <= '0;
      trunc_q <= 1'b0;
      dmac_q <= '0;
      mac_q <= MAC_RESET;
      irq_en_q <= 1'b0;
      promisc_q <= 1'b0;
      ptr_err_q <= 1'b0;
      ovf_q <= '0;
      bad_q <= '0;
      runt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
      for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      bcnt_q <= bcnt_d;
      trunc_q <= trunc_d;
      dmac_q <= dmac_d;
      mac_q <= mac_d;
      irq_en_q <= irq_en_d;
      promisc_q <= promisc_d;
      ptr_err_q <= ptr_err_d;
      ovf_q <= ovf_d;
      bad_q <= bad_d;
      runt_q <= runt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
      if (commit) len_q[slot] <= len_ent;
    end
  end

  assign buf_we = we_q;
  assign buf_addr = addr_q;
  assign buf_wdata = wdata_q;
  assign reg_rdata = rdata_q;
  assign eth_irq = irq_q;

endmodule

// File: doc/eth_rx_ring.md
Name: eth_rx_ring

Overview:
- Parametrised receive-buffer manager for the lowRISC Ethernet framing path.
- Takes the byte stream from the GMII receiver and applies destination-MAC filtering and FCS-error discard.
- Writes accepted frames into an NBUF-slot ring in an external dual-port buffer RAM and keeps a per-slot length/status table.
- Exposes a 32-bit CPU register window with producer/consumer pointers, drop counters and a level interrupt; replaces fixed 8-buffer handling.

Parameters:
NBUF, 8, number of ring slots; power of 2, 2..16; BW = $clog2(NBUF)
BUF_BYTES, 2048, bytes per slot; power of 2, 64..16384; AW = $clog2(BUF_BYTES)
MAC_RESET, 48'h230100890702, station MAC address after reset

Ports:
msoc_clk  in  1  sole clock
rstn  in  1  asynchronous active-low reset
rx_tdata  in  8  received byte
rx_tvalid  in  1  byte strobe; no backpressure
rx_tlast  in  1  last byte of frame, qualified by rx_tvalid
rx_tuser  in  1  frame error (bad FCS/frame), valid with rx_tlast
buf_we  out  1  buffer RAM byte write enable
buf_addr  out  BW+AW  {slot, byte offset}
buf_wdata  out  8  byte to write
reg_sel  in  1  register access strobe
reg_we  in  1  write when reg_sel=1
reg_addr  in  5  32-bit word index
reg_wdata  in  32  write data
reg_rdata  out  32  read data, 1-cycle latency
eth_irq  out  1  level interrupt

Behaviour:
- Pointers: head and tail are BW+1 bits. count = head - tail (mod 2^(BW+1)). full = (count == NBUF).
- FSM states IDLE, HDR, BODY, DROP. State advances only on rx_tvalid.
- IDLE, first byte:
  - full -> DROP; ovf_cnt++.
  - else -> HDR; write the byte at offset 0; byte_cnt = 1.
- HDR: write each byte and shift it into dmac; after byte 6, evaluate the filter:
  - accept if dmac[47:24]==24'h01005E, or dmac all ones, or dmac==mac_addr, or promisc.
  - accept -> BODY; reject -> DROP, nothing counted.
- BODY: write while byte_cnt < BUF_BYTES; beyond that, suppress writes and set the trunc flag. byte_cnt saturates at BUF_BYTES.
- tlast in HDR (runt, fewer than 7 bytes): discard, runt_cnt++, -> IDLE.
- tlast in BODY (the last byte is still written if room):
  - rx_tuser=1 -> discard, bad_cnt++.
  - else commit: len[head] = {trunc, byte_cnt[14:0]}; head++.
  - -> IDLE.
- tlast in DROP -> IDLE. A frame starting in IDLE with tlast on its first byte is a runt.
- Counters: all 16 bit and saturating; cleared only by reset.
- Writes: buf_we/buf_addr/buf_wdata are registered, one cycle after the accepted byte. buf_addr = {head[BW-1:0], offset}. Discarded frames leave head unchanged; the slot is reused.
- Registers, written on reg_sel&reg_we:
  - 0: mac_addr[31:0].
  - 1: {irq_en[31], promisc[30], mac_addr[47:32] at [15:0]}.
  - 2 (RO): {eth_irq[31], full[30], count[20:16], head[12:8], tail[4:0]}, zero-extended.
  - 3: tail write. Accepted only if (wdata - tail) mod 2^(BW+1) <= count; otherwise ignored and sticky ptr_err set. Read returns tail.
  - 4 (RO): {bad_cnt, ovf_cnt}.
  - 5: runt_cnt[15:0] and ptr_err[31]. A write of bit31=1 clears ptr_err.
  - 16+i, i<NBUF (RO): len[i], 16 bits zero-extended.
  - Other addresses read 0.
- Reads: reg_rdata is registered; updated on reg_sel&~reg_we, otherwise holds.
- Simultaneous commit and tail write in one cycle: both apply. Tail legality is checked against the pre-commit count.
- eth_irq is registered: irq_en & (count != 0), computed from post-update values, so it deasserts the cycle after the tail catches up.
- Reset (async, any time, including mid-frame):
  - state IDLE; head = tail = 0; all counters, ptr_err, irq_en and promisc 0.
  - mac_addr = MAC_RESET; len table 0.
  - buf_we = 0, buf_addr = 0, buf_wdata = 0, reg_rdata = 0, eth_irq = 0.
  - A frame in flight at reset release is seen mid-stream. Bytes arriving in IDLE without a frame start are treated as a new frame; the upstream receiver resets on the same rstn, so this is acceptable.

Decomposition:
- Package eth_ring_pkg: FSM state enum, register index constants, length-entry bit positions (TRUNC_BIT = 15), filter constants (MCAST_OUI = 24'h01005E).
- One sub-module, eth_mac_filter: combinational dmac/mac_addr/promisc -> accept.

Test Plan:
- Unicast 64-byte frame, dmac = MAC_RESET, tuser=0 -> 64 buf writes to slot 0 offsets 0..63; len[0]=0x0040; head=1; eth_irq=1 when irq_en=1.
- Non-matching unicast dmac 02:00:00:00:00:01, promisc=0 -> 6 writes only, head unchanged, no counter change; with promisc=1 the frame commits.
- Fill NBUF=8 with 8 frames, send a 9th -> no buf_we after the first byte check, ovf_cnt=1; write tail=1 -> count=7; the next frame commits to slot 0.
- Frame of BUF_BYTES+10 bytes -> BUF_BYTES writes; len entry = 0x8000|BUF_BYTES.
- Frame with rx_tuser=1 at tlast -> bad_cnt=1, head unchanged; 4-byte frame -> runt_cnt=1.
- Tail write 5 with count=2 -> ignored, ptr_err=1; commit and legal tail write in the same cycle -> count correct. Assert rstn mid-BODY -> all outputs 0, head=tail=0.
